// File: rtl/beta_pkg.sv
// beta_pkg: shared opcode constants, default ALUFN width and ALU-control FSM states
package beta_pkg;
    localparam int ALUFN_W_DEF = 4;
    localparam logic [5:0] OP_MUL  = 6'h22;
    localparam logic [5:0] OP_MULC = 6'h32;
    localparam logic [5:0] OP_DIV  = 6'h23;
    localparam logic [5:0] OP_DIVC = 6'h33;
    typedef enum logic [1:0] {IDLE, BUSY, VALID} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational Beta opcode decode into B-select, ALU function and latency class
module alu_op_decode
    import beta_pkg::*;
#(
    parameter int ALUFN_W = ALUFN_W_DEF
) (
    input  logic [5:0]         opcode_i,
    output logic               bsel_o,
    output logic [ALUFN_W-1:0] alufn_o,
    output logic               multi_o,
    output logic               is_div_o
);
    assign bsel_o   = ~opcode_i[4];
    assign alufn_o  = opcode_i[5] ? opcode_i[ALUFN_W-1:0] : '0;
    assign is_div_o = opcode_i == OP_DIV || opcode_i == OP_DIVC;
    assign multi_o  = is_div_o || opcode_i == OP_MUL || opcode_i == OP_MULC;
endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU-control stage that sequences multi-cycle MUL/DIV ops for EX
module alu_ctrl_stage
    import beta_pkg::*;
#(
    parameter int ALUFN_W = ALUFN_W_DEF,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = $clog2((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [5:0]         in_opcode,
    output logic               in_ready,
    input  logic               flush,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               out_bsel,
    output logic [ALUFN_W-1:0] out_alufn,
    output logic               out_busy,
    output logic [CNT_W-1:0]   out_step
);
    localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   step_q, step_d, last_q, last_d, lat;
    logic               bsel_q, bsel_d, dec_bsel, dec_multi, dec_div, accept;
    logic [ALUFN_W-1:0] alufn_q, alufn_d, dec_alufn;

    alu_op_decode #(.ALUFN_W(ALUFN_W)) u_dec (
        .opcode_i (in_opcode),
        .bsel_o   (dec_bsel),
        .alufn_o  (dec_alufn),
        .multi_o  (dec_multi),
        .is_div_o (dec_div)
    );

    // last_q keeps the final BUSY step (L-2) so the counter compare needs no subtractor per cycle
    assign lat       = dec_multi ? (dec_div ? DIV_L : MUL_L) : CNT_W'(1);
    assign in_ready  = rst_n && !flush && (state_q == IDLE || (state_q == VALID && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state_q == VALID;
    assign out_busy  = state_q == BUSY;
    assign out_step  = step_q;
    assign out_bsel  = bsel_q;
    assign out_alufn = alufn_q;

    // next state: flush wins, then accept/reload, then BUSY counting, then VALID drain
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        last_d  = last_q;
        bsel_d  = bsel_q;
        alufn_d = alufn_q;
        if (flush) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (accept) begin
            state_d = (lat == CNT_W'(1)) ? VALID : BUSY;
            step_d  = '0;
            last_d  = lat - CNT_W'(2);
            bsel_d  = dec_bsel;
            alufn_d = dec_alufn;
        end else if (state_q == BUSY) begin
            state_d = (step_q == last_q) ? VALID : BUSY;
            step_d  = step_q + CNT_W'(1);
        end else if (state_q == VALID && out_ready) begin
            state_d = IDLE;
            step_d  = '0;
        end
    end

    // pipeline register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            last_q  <= '0;
            bsel_q  <= 1'b0;
            alufn_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            last_q  <= last_d;
            bsel_q  <= bsel_d;
            alufn_q <= alufn_d;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: directed and random checks of two parameterisations against an age-based model
module tb_alu_ctrl_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [5:0] in_opcode = '0;
    logic [1:0] irdy, ov, obs, ob;
    logic [3:0] alufn0, alufn1, step0;
    logic [2:0] step1;
    int total = 0, bad = 0;

    int mul_l[2] = '{4, 1};
    int div_l[2] = '{8, 3};
    bit held[2], known[2];
    int age[2], lat[2];
    logic m_bsel[2];
    logic [3:0] m_alufn[2];
    logic [5:0] ops[8] = '{6'h22, 6'h32, 6'h23, 6'h33, 6'h20, 6'h35, 6'h18, 6'h29};

    always #5 clk = ~clk;

    alu_ctrl_stage u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode), .in_ready(irdy[0]),
        .flush(flush), .out_ready(out_ready), .out_valid(ov[0]), .out_bsel(ob[0]),
        .out_alufn(alufn0), .out_busy(obs[0]), .out_step(step0)
    );

    alu_ctrl_stage #(.ALUFN_W(4), .MUL_LAT(1), .DIV_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode), .in_ready(irdy[1]),
        .flush(flush), .out_ready(out_ready), .out_valid(ov[1]), .out_bsel(ob[1]),
        .out_alufn(alufn1), .out_busy(obs[1]), .out_step(step1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(int k, logic [5:0] op);
        if (op == 6'h22 || op == 6'h32) return mul_l[k];
        if (op == 6'h23 || op == 6'h33) return div_l[k];
        return 1;
    endfunction

    function automatic bit m_done(int k);
        return held[k] && age[k] >= lat[k] - 1;
    endfunction

    function automatic logic m_ready(int k);
        return rst_n && !flush && (!held[k] || (m_done(k) && out_ready));
    endfunction

    task automatic compare(int k);
        logic [3:0] st;
        logic [3:0] af;
        st = (k == 0) ? step0 : {1'b0, step1};
        af = (k == 0) ? alufn0 : alufn1;
        if (known[k] || !rst_n) check($sformatf("u%0d.in_ready", k), irdy[k], m_ready(k));
        if (!known[k]) return;
        check($sformatf("u%0d.out_valid", k), ov[k], m_done(k));
        check($sformatf("u%0d.out_busy", k), obs[k], held[k] && !m_done(k));
        if (held[k]) check($sformatf("u%0d.out_step", k), st, age[k]);
        if (m_done(k)) begin
            check($sformatf("u%0d.out_bsel", k), ob[k], m_bsel[k]);
            check($sformatf("u%0d.out_alufn", k), af, m_alufn[k]);
        end
    endtask

    task automatic advance(int k);
        logic r;
        r = m_ready(k);
        if (!rst_n) begin
            held[k] = 0; age[k] = 0; m_bsel[k] = 0; m_alufn[k] = 0; known[k] = 1;
        end else if (flush) begin
            held[k] = 0; age[k] = 0;
        end else if (in_valid && r) begin
            held[k] = 1; age[k] = 0; lat[k] = lat_of(k, in_opcode);
            m_bsel[k] = ~in_opcode[4];
            m_alufn[k] = in_opcode[5] ? in_opcode[3:0] : 4'h0;
        end else if (m_done(k)) begin
            if (out_ready) held[k] = 0;
        end else if (held[k]) begin
            age[k]++;
        end
    endtask

    task automatic cycle(input logic rn, input logic iv, input logic [5:0] op, input logic fl, input logic ordy);
        @(negedge clk);
        rst_n = rn; in_valid = iv; in_opcode = op; flush = fl; out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) compare(k);
        for (int k = 0; k < 2; k++) advance(k);
    endtask

    initial begin
        cycle(0, 1, 6'h20, 0, 1);
        cycle(0, 1, 6'h20, 0, 1);
        check("rst.out_valid", ov[0], 0);
        check("rst.out_alufn", alufn0, 0);
        check("rst.out_bsel", ob[0], 0);
        check("rst.out_step", step0, 0);
        cycle(1, 0, 6'h00, 0, 1);
        check("rst.in_ready_after", irdy[0], 1);

        cycle(1, 1, 6'h20, 0, 1);
        cycle(1, 1, 6'h35, 0, 1);
        check("b2b.op0", {ov[0], ob[0], alufn0}, {1'b1, 1'b1, 4'h0});
        cycle(1, 1, 6'h18, 0, 1);
        check("b2b.op1", {ov[0], ob[0], alufn0}, {1'b1, 1'b0, 4'h5});
        cycle(1, 0, 6'h00, 0, 1);
        check("b2b.op2", {ov[0], ob[0], alufn0, obs[0]}, {1'b1, 1'b0, 4'h0, 1'b0});
        cycle(1, 0, 6'h00, 0, 1);

        cycle(1, 1, 6'h22, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 6'h20, 0, 1);
            check("mul.busy", {obs[0], ov[0], irdy[0]}, {1'b1, 1'b0, 1'b0});
            check("mul.step", step0, i);
        end
        cycle(1, 0, 6'h00, 0, 1);
        check("mul.done", {ov[0], step0, alufn0}, {1'b1, 4'd3, 4'h2});
        cycle(1, 0, 6'h00, 0, 1);

        cycle(1, 1, 6'h29, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 6'h2A, 0, 0);
            check("bp.hold", {ov[0], irdy[0], ob[0], alufn0}, {1'b1, 1'b0, 1'b1, 4'h9});
        end
        cycle(1, 1, 6'h2A, 0, 1);
        cycle(1, 0, 6'h00, 0, 1);
        check("bp.next", {ov[0], ob[0], alufn0}, {1'b1, 1'b1, 4'hA});

        cycle(1, 1, 6'h23, 0, 1);
        cycle(1, 0, 6'h00, 0, 1);
        cycle(1, 1, 6'h20, 1, 1);
        check("flush.at_step1", {obs[0], step0, irdy[0]}, {1'b1, 4'd1, 1'b0});
        cycle(1, 1, 6'h20, 0, 1);
        check("flush.after", {ov[0], obs[0], step0, irdy[0]}, {1'b0, 1'b0, 4'd0, 1'b1});
        cycle(1, 0, 6'h00, 0, 1);
        check("flush.next_op", {ov[0], ob[0], alufn0}, {1'b1, 1'b1, 4'h0});

        cycle(1, 0, 6'h00, 1, 1);
        cycle(1, 1, 6'h32, 0, 1);
        cycle(1, 0, 6'h00, 1, 1);
        check("sweep.mulc", {ov[1], step1, alufn1}, {1'b1, 3'd0, 4'h2});
        cycle(1, 1, 6'h33, 0, 1);
        cycle(1, 0, 6'h00, 0, 1);
        check("sweep.div_s0", {obs[1], step1}, {1'b1, 3'd0});
        cycle(1, 0, 6'h00, 0, 1);
        check("sweep.div_s1", {obs[1], step1}, {1'b1, 3'd1});
        cycle(1, 0, 6'h00, 0, 1);
        check("sweep.div_done", {ov[1], step1, alufn1}, {1'b1, 3'd2, 4'h3});

        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) ? ops[$urandom_range(0, 7)] : 6'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
